fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch and program-counter stage of the RISC-V core. Owns the architectural PC, issues requests to instruction memory over a valid/ready handshake, holds the returned instruction for decode, and on retirement consumes the branch unit's `NextPCSrc` decision and the ALU-computed target to select the next PC. A misaligned taken target redirects to a trap vector.

## Interface

- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `TRAP_PC`, 32'h0000_0100, PC loaded on misaligned-target trap.

- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_addr`  out  32  fetch address (= PC); stable while `imem_req_valid`.
- `imem_rsp_valid`  in  1  response data valid (one-cycle pulse).
- `imem_rsp_data`  in  32  instruction word.
- `instr`  out  32  instruction presented to decode.
- `instr_pc`  out  32  PC of `instr`.
- `instr_valid`  out  1  `instr` is valid and executing.
- `retire`  in  1  core finished current instruction; samples `NextPCSrc`, `branch_target`.
- `NextPCSrc`  in  1  branch unit decision: 1 = take `branch_target`, 0 = PC+4.
- `branch_target`  in  32  ALU-computed jump/branch target.
- `trap`  out  1  one-cycle pulse: misaligned taken target.
- `trap_epc`  out  32  PC of the instruction that caused the last trap.
- `instret`  out  32  retired-instruction count.

## Operation

- FSM states: FETCH, WAIT_RSP, EXEC.
- FETCH: `imem_req_valid`=1, `imem_addr`=PC. On `imem_req_ready` -> WAIT_RSP. Request held unchanged until accepted.
- WAIT_RSP: on `imem_rsp_valid`, latch `imem_rsp_data` into `instr`, PC into `instr_pc` -> EXEC. Responses in FETCH or EXEC are ignored.
- EXEC: `instr_valid`=1. On `retire`:
  - target = `branch_target` with bit 0 forced to 0 (JALR rule).
  - `NextPCSrc`=0: PC <= PC+4.
  - `NextPCSrc`=1, target[1]=0: PC <= target.
  - `NextPCSrc`=1, target[1]=1: PC <= `TRAP_PC`, `trap` pulses, `trap_epc` <= `instr_pc`.
  - `instret` += 1 in all three cases (trapping instruction counts as retired); -> FETCH.
- `retire` outside EXEC ignored.
- Arithmetic: PC+4 and `instret` wrap modulo 2^32; no overflow flag.

## Timing

- Reset values: PC=`RESET_PC`, state=FETCH, `imem_req_valid`=0 while `rst_n`=0, `imem_addr`=`RESET_PC`, `instr`=0, `instr_pc`=0, `instr_valid`=0, `trap`=0, `trap_epc`=0, `instret`=0.
- `imem_req_valid` rises combinationally from state: first cycle after `rst_n` deasserts.
- Best case 3 cycles/instruction: cycle 0 request accepted, cycle 1 response, cycle 2 EXEC with `retire` -> cycle 3 FETCH of next PC.
- `instr_valid`, `instr`, `instr_pc` registered; valid first cycle after response, drop the cycle after `retire`.
- `trap` asserted exactly the cycle after the trapping `retire` (registered), coincident with FETCH at `TRAP_PC`.
- Reset mid-operation: any state returns to FETCH immediately; outstanding request abandoned (memory shares `rst_n`).
- PC=32'hFFFF_FFFC, not taken -> next PC 32'h0000_0000.

## Structure

- Shared package `riscv_pkg`: `fetch_state_t` enum (FETCH, WAIT_RSP, EXEC), `XLEN`=32, `PC_STEP`=4.
- One combinational sub-module `next_pc_sel`: inputs PC, `NextPCSrc`, `branch_target`; outputs next PC and misalign flag. FSM, registers and counters stay in `fetch_unit`.

## Test plan

- Reset release, memory ready always, response next cycle, `retire` each EXEC with `NextPCSrc`=0 -> `imem_addr` 0x0, 0x4, 0x8 every 3 cycles; `instret`=3 after third retire.
- `imem_req_ready` low 4 cycles -> `imem_req_valid`=1, `imem_addr` stable throughout; fetch completes on ready.
- PC=0x10, `retire` with `NextPCSrc`=1, `branch_target`=0x41 -> next `imem_addr`=0x40, no `trap`.
- PC=0x20, `retire` with `NextPCSrc`=1, `branch_target`=0x102 -> `trap` one cycle, `trap_epc`=0x20, `imem_addr`=0x100, `instret` incremented.
- Spurious `imem_rsp_valid` in FETCH and `retire` in WAIT_RSP -> no state, PC or `instret` change.
- `rst_n` asserted in EXEC with `instr_valid`=1 -> all outputs to reset values same cycle, `imem_addr`=`RESET_PC` after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Types and constants shared by the fetch stage and its next-PC helper.
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        WAIT_RSP = 2'd1,
        EXEC     = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC selection: sequential PC, taken branch target (bit 0 cleared),
// or the trap vector when a taken target is not word aligned.
module next_pc_sel
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] TRAP_PC = 32'h0000_0100
) (
    input  logic [XLEN-1:0] pc,
    input  logic            NextPCSrc,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] next_pc,
    output logic            misalign
);

    logic [XLEN-1:0] target;

    // JALR semantics: the LSB of a computed target is always discarded.
    assign target   = {branch_target[XLEN-1:1], 1'b0};
    assign misalign = NextPCSrc & target[1];

    always_comb begin
        next_pc = pc + XLEN'(PC_STEP);
        if (NextPCSrc) begin
            next_pc = misalign ? TRAP_PC : target;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / PC stage: requests instructions, holds them for decode
// and selects the next PC when the current instruction retires.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_PC  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            retire,
    input  logic            NextPCSrc,
    input  logic [XLEN-1:0] branch_target,
    output logic            trap,
    output logic [XLEN-1:0] trap_epc,
    output logic [XLEN-1:0] instret
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            instr_valid_q, instr_valid_d;
    logic            trap_q, trap_d;
    logic [XLEN-1:0] trap_epc_q, trap_epc_d;
    logic [XLEN-1:0] instret_q, instret_d;

    logic [XLEN-1:0] sel_next_pc;
    logic            sel_misalign;

    next_pc_sel #(
        .TRAP_PC(TRAP_PC)
    ) u_next_pc_sel (
        .pc           (pc_q),
        .NextPCSrc    (NextPCSrc),
        .branch_target(branch_target),
        .next_pc      (sel_next_pc),
        .misalign     (sel_misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            trap_q        <= 1'b0;
            trap_epc_q    <= '0;
            instret_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            trap_q        <= trap_d;
            trap_epc_q    <= trap_epc_d;
            instret_q     <= instret_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        trap_d        = 1'b0;
        trap_epc_d    = trap_epc_q;
        instret_d     = instret_q;

        case (state_q)
            FETCH: begin
                if (imem_req_ready) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (imem_rsp_valid) begin
                    instr_d       = imem_rsp_data;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = EXEC;
                end
            end
            EXEC: begin
                // A trapping instruction still counts as retired.
                if (retire) begin
                    pc_d          = sel_next_pc;
                    trap_d        = sel_misalign;
                    instret_d     = instret_q + 1'b1;
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
                    if (sel_misalign) begin
                        trap_epc_d = instr_pc_q;
                    end
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Gated by rst_n so no request is visible while reset is held.
    assign imem_req_valid = rst_n && (state_q == FETCH);
    assign imem_addr      = pc_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign instr_valid    = instr_valid_q;
    assign trap           = trap_q;
    assign trap_epc       = trap_epc_q;
    assign instret        = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetch addresses and instruction
// words are queued when stimulus is driven and compared when the DUT shows them.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        retire;
    logic        NextPCSrc;
    logic [31:0] branch_target;
    logic        trap;
    logic [31:0] trap_epc;
    logic [31:0] instret;

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .retire        (retire),
        .NextPCSrc     (NextPCSrc),
        .branch_target (branch_target),
        .trap          (trap),
        .trap_epc      (trap_epc),
        .instret       (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];

    logic [31:0] model_pc;
    logic [31:0] model_instret;
    logic [31:0] model_epc;
    int          req_cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        logic [31:0] exp;
        while (!imem_req_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq("req_valid", {31'd0, imem_req_valid}, 32'd1);
        req_cyc = cyc;
        if (exp_addr_q.size() == 0) begin
            check_eq("addr_queue_empty", 32'd0, 32'd1);
            exp = model_pc;
        end else begin
            exp = exp_addr_q.pop_front();
        end
        check_eq("imem_addr", imem_addr, exp);
        $display("fetch req addr=%08h instret=%0d", imem_addr, instret);
    endtask

    // One full instruction: request (optionally stalled), response, retire.
    task automatic do_instr(input logic src, input logic [31:0] bt, input int rdelay,
                            input bit spur_rsp, input bit spur_ret);
        logic [31:0] w;
        logic [31:0] t;
        logic [31:0] nxt;
        logic        exp_trap;
        logic [31:0] got_w;
        wait_req();
        for (int i = 0; i < rdelay; i++) begin
            if (spur_rsp && i == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
            tick();
            imem_rsp_valid = 1'b0;
            check_eq("stall_valid", {31'd0, imem_req_valid}, 32'd1);
            check_eq("stall_addr", imem_addr, model_pc);
            check_eq("stall_ivalid", {31'd0, instr_valid}, 32'd0);
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        check_eq("trap_low", {31'd0, trap}, 32'd0);
        check_eq("wait_req_low", {31'd0, imem_req_valid}, 32'd0);
        if (spur_ret) begin
            retire        = 1'b1;
            NextPCSrc     = 1'b1;
            branch_target = 32'h0000_0102;
            tick();
            retire = 1'b0;
            check_eq("spur_ret_instret", instret, model_instret);
            check_eq("spur_ret_trap", {31'd0, trap}, 32'd0);
            check_eq("spur_ret_ivalid", {31'd0, instr_valid}, 32'd0);
        end
        w = $urandom;
        exp_instr_q.push_back(w);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = w;
        tick();
        imem_rsp_valid = 1'b0;
        got_w = exp_instr_q.pop_front();
        check_eq("instr", instr, got_w);
        check_eq("instr_pc", instr_pc, model_pc);
        check_eq("instr_valid", {31'd0, instr_valid}, 32'd1);

        t = bt & 32'hFFFF_FFFE;
        exp_trap = 1'b0;
        if (!src) nxt = model_pc + 32'd4;
        else if (t[1]) begin
            nxt       = 32'h0000_0100;
            exp_trap  = 1'b1;
            model_epc = model_pc;
        end else nxt = t;
        model_instret = model_instret + 32'd1;
        exp_addr_q.push_back(nxt);

        retire        = 1'b1;
        NextPCSrc     = src;
        branch_target = bt;
        tick();
        retire    = 1'b0;
        NextPCSrc = 1'b0;
        check_eq("trap", {31'd0, trap}, {31'd0, exp_trap});
        check_eq("trap_epc", trap_epc, model_epc);
        check_eq("instret", instret, model_instret);
        check_eq("ivalid_drop", {31'd0, instr_valid}, 32'd0);
        $display("retire pc=%08h src=%0d bt=%08h -> next=%08h trap=%0d instret=%0d",
                 model_pc, src, bt, nxt, trap, instret);
        model_pc = nxt;
    endtask

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
        check_eq({pfx, "_addr"}, imem_addr, 32'd0);
        check_eq({pfx, "_instr"}, instr, 32'd0);
        check_eq({pfx, "_instr_pc"}, instr_pc, 32'd0);
        check_eq({pfx, "_ivalid"}, {31'd0, instr_valid}, 32'd0);
        check_eq({pfx, "_trap"}, {31'd0, trap}, 32'd0);
        check_eq({pfx, "_epc"}, trap_epc, 32'd0);
        check_eq({pfx, "_instret"}, instret, 32'd0);
    endtask

    initial begin
        int c0;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        retire         = 1'b0;
        NextPCSrc      = 1'b0;
        branch_target  = '0;
        model_pc       = 32'd0;
        model_instret  = 32'd0;
        model_epc      = 32'd0;
        req_cyc        = 0;

        repeat (3) tick();
        check_reset_vals("rst");
        rst_n = 1'b1;
        #1;
        check_eq("req_after_rst", {31'd0, imem_req_valid}, 32'd1);
        exp_addr_q.push_back(32'd0);

        // Back-to-back sequential fetches, best case 3 cycles each.
        do_instr(1'b0, 32'd0, 0, 0, 0);
        c0 = req_cyc;
        do_instr(1'b0, 32'd0, 0, 0, 0);
        check_eq("cpi_1", req_cyc - c0, 32'd3);
        c0 = req_cyc;
        do_instr(1'b0, 32'd0, 0, 0, 0);
        check_eq("cpi_2", req_cyc - c0, 32'd3);
        check_eq("instret_3", instret, 32'd3);

        // Stalled request, spurious response in FETCH, spurious retire in WAIT_RSP.
        do_instr(1'b0, 32'd0, 4, 1, 1);
        // PC=0x10: taken target 0x41 -> 0x40, no trap.
        do_instr(1'b1, 32'h0000_0041, 0, 0, 0);
        do_instr(1'b1, 32'h0000_0020, 1, 0, 0);
        // PC=0x20: misaligned target 0x102 -> trap to 0x100.
        do_instr(1'b1, 32'h0000_0102, 0, 0, 0);
        // Wrap: jump to 0xFFFFFFFC then fall through to 0.
        do_instr(1'b1, 32'hFFFF_FFFD, 2, 0, 0);
        do_instr(1'b0, 32'd0, 0, 0, 0);

        // Reset asserted while EXEC holds a valid instruction.
        wait_req();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1234_5678;
        tick();
        imem_rsp_valid = 1'b0;
        check_eq("pre_rst_ivalid", {31'd0, instr_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        model_pc      = 32'd0;
        model_instret = 32'd0;
        model_epc     = 32'd0;
        exp_addr_q.delete();
        exp_addr_q.push_back(32'd0);
        do_instr(1'b0, 32'd0, 0, 0, 0);
        check_eq("post_rst_instret", instret, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
